// File: rtl/legv8_pkg.sv
// Shared definitions for the LEGv8 pipeline: memory-stage FSM states and
// the default data-memory acknowledge timeout.
package legv8_pkg;

    localparam int TIMEOUT_DEFAULT = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

endpackage

// File: rtl/flopr.sv
// Resettable register with load enable, used for pipeline boundary registers.
module flopr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear on synchronous active-low reset, otherwise load only when enabled
    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/memory_access.sv
// Memory stage of the LEGv8 pipeline: captures the execute-stage result into
// the EX/MEM register, runs the data-memory handshake with a bounded wait,
// and presents a one-cycle valid_M pulse with the results of each op.
module memory_access
    import legv8_pkg::*;
#(
    parameter int N       = 64,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,

    input  logic         valid_E,
    input  logic [N-1:0] aluResult_E,
    input  logic [N-1:0] writeData_E,
    input  logic [N-1:0] PCBranch_E,
    input  logic         zero_E,
    input  logic         Branch_E,
    input  logic         MemRead_E,
    input  logic         MemWrite_E,
    input  logic         RegWrite_E,
    input  logic         MemtoReg_E,
    input  logic [4:0]   rd_E,
    output logic         stall_E,

    output logic         dmem_req,
    output logic         dmem_we,
    output logic [N-1:0] dmem_addr,
    output logic [N-1:0] dmem_wdata,
    input  logic         dmem_ack,
    input  logic [N-1:0] dmem_rdata,

    output logic         valid_M,
    output logic [N-1:0] readData_M,
    output logic [N-1:0] aluResult_M,
    output logic [N-1:0] PCBranch_M,
    output logic [4:0]   rd_M,
    output logic         RegWrite_M,
    output logic         MemtoReg_M,
    output logic         PCSrc_M,
    output logic         err_M
);

    localparam int RW = 3 * N + 11;
    localparam int CW = $clog2(TIMEOUT + 1);

    mem_state_t state;
    mem_state_t next_state;

    logic [CW-1:0] wait_count;

    logic [RW-1:0] exmem_d;
    logic [RW-1:0] exmem_q;

    logic [N-1:0] alu_q;
    logic [N-1:0] wdata_q;
    logic [N-1:0] pcb_q;
    logic         zero_q;
    logic         branch_q;
    logic         memread_q;
    logic         memwrite_q;
    logic         regwrite_q;
    logic         memtoreg_q;
    logic [4:0]   rd_q;

    logic mem_op_E;
    logic illegal_E;
    logic capture;
    logic ack_done;
    logic timeout_done;
    logic valid_next;
    logic err_next;

    assign mem_op_E  = MemRead_E | MemWrite_E;
    assign illegal_E = (MemRead_E & MemWrite_E) |
                       (mem_op_E & (aluResult_E[2:0] != 3'b000));

    assign stall_E = (state == ACCESS);

    assign exmem_d = {aluResult_E, writeData_E, PCBranch_E, zero_E, Branch_E,
                      MemRead_E, MemWrite_E, RegWrite_E, MemtoReg_E, rd_E};

    flopr #(.WIDTH(RW)) u_exmem (
        .clk   (clk),
        .reset (reset),
        .en    (capture),
        .d     (exmem_d),
        .q     (exmem_q)
    );

    assign {alu_q, wdata_q, pcb_q, zero_q, branch_q,
            memread_q, memwrite_q, regwrite_q, memtoreg_q, rd_q} = exmem_q;

    // Memory port is only driven while an access is outstanding
    assign dmem_req   = (state == ACCESS);
    assign dmem_we    = dmem_req & memwrite_q;
    assign dmem_addr  = dmem_req ? alu_q   : '0;
    assign dmem_wdata = dmem_req ? wdata_q : '0;

    assign aluResult_M = alu_q;
    assign PCBranch_M  = pcb_q;
    assign rd_M        = rd_q;
    assign MemtoReg_M  = memtoreg_q;
    assign PCSrc_M     = branch_q & zero_q;
    assign RegWrite_M  = regwrite_q & ~err_M;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic plus completion events; ack beats timeout in the same cycle
    always_comb begin
        next_state   = state;
        capture      = 1'b0;
        ack_done     = 1'b0;
        timeout_done = 1'b0;
        valid_next   = 1'b0;
        err_next     = 1'b0;
        case (state)
            IDLE: begin
                capture = valid_E;
                if (valid_E) begin
                    if (!mem_op_E) begin
                        valid_next = 1'b1;
                    end else if (illegal_E) begin
                        valid_next = 1'b1;
                        err_next   = 1'b1;
                    end else begin
                        next_state = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (dmem_ack) begin
                    ack_done   = 1'b1;
                    valid_next = 1'b1;
                    next_state = IDLE;
                end else if (wait_count == CW'(TIMEOUT - 1)) begin
                    timeout_done = 1'b1;
                    valid_next   = 1'b1;
                    err_next     = 1'b1;
                    next_state   = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Wait counter: held at zero in IDLE so it starts clean on each access
    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_count <= '0;
        end else if (state == IDLE) begin
            wait_count <= '0;
        end else if (!dmem_ack && !timeout_done) begin
            wait_count <= wait_count + 1'b1;
        end
    end

    // Result pulse, error flag and load data for the op leaving this stage
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_M    <= 1'b0;
            err_M      <= 1'b0;
            readData_M <= '0;
        end else begin
            valid_M <= valid_next;
            err_M   <= err_next;
            if (capture) begin
                readData_M <= '0;
            end else if (ack_done && memread_q) begin
                readData_M <= dmem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: a scoreboard queue holds the
// predicted result of every captured op and is drained on each valid_M pulse.
module tb_memory_access;

    localparam int N       = 64;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic [N-1:0] readData;
        logic [N-1:0] aluResult;
        logic [N-1:0] pcBranch;
        logic [4:0]   rd;
        logic         regWrite;
        logic         memtoReg;
        logic         pcSrc;
        logic         err;
    } expect_t;

    logic         clk;
    logic         reset;
    logic         valid_E;
    logic [N-1:0] aluResult_E;
    logic [N-1:0] writeData_E;
    logic [N-1:0] PCBranch_E;
    logic         zero_E;
    logic         Branch_E;
    logic         MemRead_E;
    logic         MemWrite_E;
    logic         RegWrite_E;
    logic         MemtoReg_E;
    logic [4:0]   rd_E;
    logic         stall_E;
    logic         dmem_req;
    logic         dmem_we;
    logic [N-1:0] dmem_addr;
    logic [N-1:0] dmem_wdata;
    logic         dmem_ack;
    logic [N-1:0] dmem_rdata;
    logic         valid_M;
    logic [N-1:0] readData_M;
    logic [N-1:0] aluResult_M;
    logic [N-1:0] PCBranch_M;
    logic [4:0]   rd_M;
    logic         RegWrite_M;
    logic         MemtoReg_M;
    logic         PCSrc_M;
    logic         err_M;

    expect_t expectQ[$];
    int      assertCount = 0;
    int      failCount   = 0;

    memory_access #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .valid_E     (valid_E),
        .aluResult_E (aluResult_E),
        .writeData_E (writeData_E),
        .PCBranch_E  (PCBranch_E),
        .zero_E      (zero_E),
        .Branch_E    (Branch_E),
        .MemRead_E   (MemRead_E),
        .MemWrite_E  (MemWrite_E),
        .RegWrite_E  (RegWrite_E),
        .MemtoReg_E  (MemtoReg_E),
        .rd_E        (rd_E),
        .stall_E     (stall_E),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_ack    (dmem_ack),
        .dmem_rdata  (dmem_rdata),
        .valid_M     (valid_M),
        .readData_M  (readData_M),
        .aluResult_M (aluResult_M),
        .PCBranch_M  (PCBranch_M),
        .rd_M        (rd_M),
        .RegWrite_M  (RegWrite_M),
        .MemtoReg_M  (MemtoReg_M),
        .PCSrc_M     (PCSrc_M),
        .err_M       (err_M)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference model of the result an op should produce
    function automatic expect_t predict(input logic memRead, input logic memWrite,
                                        input logic regWrite, input logic memtoReg,
                                        input logic branch, input logic zero,
                                        input logic [N-1:0] addr, input logic [N-1:0] pcBranch,
                                        input logic [4:0] rd, input int ackAfter,
                                        input logic [N-1:0] rdata);
        expect_t e;
        logic isMem;
        logic isIllegal;
        logic timedOut;
        isMem     = memRead | memWrite;
        isIllegal = (memRead & memWrite) | (isMem & (addr[2:0] != 3'b000));
        timedOut  = isMem & ~isIllegal & ((ackAfter < 1) || (ackAfter > TIMEOUT));
        e.err       = isIllegal | timedOut;
        e.readData  = (memRead && !isIllegal && !timedOut) ? rdata : '0;
        e.aluResult = addr;
        e.pcBranch  = pcBranch;
        e.rd        = rd;
        e.regWrite  = regWrite & ~e.err;
        e.memtoReg  = memtoReg;
        e.pcSrc     = branch & zero;
        return e;
    endfunction

    // Drive one op, play the memory side with ackAfter (0 = never), check handshake
    task automatic applyStimulus(input logic memRead, input logic memWrite,
                                 input logic regWrite, input logic memtoReg,
                                 input logic branch, input logic zero,
                                 input logic [N-1:0] addr, input logic [N-1:0] wdata,
                                 input logic [N-1:0] pcBranch, input logic [4:0] rd,
                                 input int ackAfter, input logic [N-1:0] rdata);
        logic isMem;
        logic isIllegal;
        int   reqCycles;
        int   expReq;
        bit   done;
        isMem     = memRead | memWrite;
        isIllegal = (memRead & memWrite) | (isMem & (addr[2:0] != 3'b000));
        for (int w = 0; w < 50 && stall_E; w++) @(negedge clk);
        checkOutput("idle_before_op", 64'(stall_E), 64'd0);
        valid_E     = 1'b1;
        MemRead_E   = memRead;
        MemWrite_E  = memWrite;
        RegWrite_E  = regWrite;
        MemtoReg_E  = memtoReg;
        Branch_E    = branch;
        zero_E      = zero;
        aluResult_E = addr;
        writeData_E = wdata;
        PCBranch_E  = pcBranch;
        rd_E        = rd;
        expectQ.push_back(predict(memRead, memWrite, regWrite, memtoReg, branch, zero,
                                  addr, pcBranch, rd, ackAfter, rdata));
        @(negedge clk);
        valid_E = 1'b0;
        if (isMem && !isIllegal) begin
            reqCycles = 0;
            done      = 1'b0;
            for (int c = 0; c < TIMEOUT + 4 && !done; c++) begin
                if (dmem_req) begin
                    reqCycles++;
                    checkOutput("stall_in_access", 64'(stall_E), 64'd1);
                    checkOutput("dmem_addr", dmem_addr, addr);
                    checkOutput("dmem_we", 64'(dmem_we), 64'(memWrite));
                    if (memWrite) checkOutput("dmem_wdata", dmem_wdata, wdata);
                    if (reqCycles == ackAfter) begin
                        dmem_ack   = 1'b1;
                        dmem_rdata = rdata;
                    end
                    @(negedge clk);
                    dmem_ack   = 1'b0;
                    dmem_rdata = '0;
                end else begin
                    done = 1'b1;
                end
            end
            expReq = (ackAfter >= 1 && ackAfter <= TIMEOUT) ? ackAfter : TIMEOUT;
            checkOutput("req_cycles", 64'(reqCycles), 64'(expReq));
            checkOutput("valid_M_after_access", 64'(valid_M), 64'd1);
            checkOutput("stall_released", 64'(stall_E), 64'd0);
        end else begin
            checkOutput("no_req", 64'(dmem_req), 64'd0);
            checkOutput("no_stall", 64'(stall_E), 64'd0);
            checkOutput("valid_M_latency1", 64'(valid_M), 64'd1);
        end
    endtask

    // Scoreboard drain: every valid_M pulse must match the oldest prediction
    always @(negedge clk) begin
        if (reset === 1'b1 && valid_M === 1'b1) begin
            if (expectQ.size() == 0) begin
                checkOutput("unexpected_valid_M", 64'(valid_M), 64'd0);
            end else begin
                expect_t e;
                e = expectQ.pop_front();
                checkOutput("readData_M", readData_M, e.readData);
                checkOutput("aluResult_M", aluResult_M, e.aluResult);
                checkOutput("PCBranch_M", PCBranch_M, e.pcBranch);
                checkOutput("rd_M", 64'(rd_M), 64'(e.rd));
                checkOutput("RegWrite_M", 64'(RegWrite_M), 64'(e.regWrite));
                checkOutput("MemtoReg_M", 64'(MemtoReg_M), 64'(e.memtoReg));
                checkOutput("PCSrc_M", 64'(PCSrc_M), 64'(e.pcSrc));
                checkOutput("err_M", 64'(err_M), 64'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset       = 1'b0;
        valid_E     = 1'b0;
        aluResult_E = '0;
        writeData_E = '0;
        PCBranch_E  = '0;
        zero_E      = 1'b0;
        Branch_E    = 1'b0;
        MemRead_E   = 1'b0;
        MemWrite_E  = 1'b0;
        RegWrite_E  = 1'b0;
        MemtoReg_E  = 1'b0;
        rd_E        = '0;
        dmem_ack    = 1'b0;
        dmem_rdata  = '0;

        repeat (3) @(negedge clk);
        checkOutput("reset_stall_E", 64'(stall_E), 64'd0);
        checkOutput("reset_dmem_req", 64'(dmem_req), 64'd0);
        checkOutput("reset_dmem_we", 64'(dmem_we), 64'd0);
        checkOutput("reset_dmem_addr", dmem_addr, 64'd0);
        checkOutput("reset_valid_M", 64'(valid_M), 64'd0);
        checkOutput("reset_err_M", 64'(err_M), 64'd0);
        checkOutput("reset_readData_M", readData_M, 64'd0);
        checkOutput("reset_aluResult_M", aluResult_M, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        $display("[TB] non-memory ADD");
        applyStimulus(0, 0, 1, 0, 0, 0, 64'h10, 64'h0, 64'h0, 5'd3, 0, 64'h0);
        $display("[TB] load 0x40, ack after 3");
        applyStimulus(1, 0, 1, 1, 0, 0, 64'h40, 64'h0, 64'h0, 5'd4, 3, 64'hDEAD);
        $display("[TB] store with no ack (timeout)");
        applyStimulus(0, 1, 1, 0, 0, 0, 64'h80, 64'h1234_5678, 64'h0, 5'd5, 0, 64'h0);
        $display("[TB] misaligned load 0x43");
        applyStimulus(1, 0, 1, 1, 0, 0, 64'h43, 64'h0, 64'h0, 5'd6, 1, 64'hBEEF);
        $display("[TB] read and write together");
        applyStimulus(1, 1, 1, 0, 0, 0, 64'h88, 64'h55, 64'h0, 5'd7, 1, 64'h77);
        $display("[TB] taken and not-taken branch");
        applyStimulus(0, 0, 0, 0, 1, 1, 64'h0, 64'h0, 64'h100, 5'd0, 0, 64'h0);
        applyStimulus(0, 0, 0, 0, 1, 0, 64'h8, 64'h0, 64'h100, 5'd0, 0, 64'h0);
        $display("[TB] ack on timeout cycle");
        applyStimulus(1, 0, 1, 1, 0, 0, 64'h98, 64'h0, 64'h0, 5'd9, TIMEOUT, 64'hCAFE_F00D);
        $display("[TB] store acked after 1");
        applyStimulus(0, 1, 0, 0, 0, 0, 64'hA0, 64'hABCD, 64'h0, 5'd10, 1, 64'hFFFF);

        $display("[TB] ack while idle");
        dmem_ack   = 1'b1;
        dmem_rdata = 64'hBAD;
        @(negedge clk);
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        checkOutput("idle_ack_valid_M", 64'(valid_M), 64'd0);
        checkOutput("idle_ack_stall", 64'(stall_E), 64'd0);
        @(negedge clk);
        checkOutput("idle_ack_valid_M_late", 64'(valid_M), 64'd0);

        $display("[TB] back-to-back non-memory ops");
        for (int i = 0; i < 4; i++) begin
            valid_E     = 1'b1;
            MemRead_E   = 1'b0;
            MemWrite_E  = 1'b0;
            RegWrite_E  = 1'b1;
            MemtoReg_E  = 1'b0;
            Branch_E    = 1'b0;
            zero_E      = 1'b0;
            aluResult_E = 64'h200 + 64'(i * 8);
            PCBranch_E  = 64'h0;
            rd_E        = 5'(i + 11);
            expectQ.push_back(predict(0, 0, 1, 0, 0, 0, aluResult_E, 64'h0, rd_E, 0, 64'h0));
            @(negedge clk);
            checkOutput("b2b_valid_M", 64'(valid_M), 64'd1);
            checkOutput("b2b_stall", 64'(stall_E), 64'd0);
        end
        valid_E = 1'b0;
        @(negedge clk);
        checkOutput("b2b_valid_M_drop", 64'(valid_M), 64'd0);

        $display("[TB] reset on second access cycle");
        valid_E     = 1'b1;
        MemRead_E   = 1'b1;
        MemWrite_E  = 1'b0;
        RegWrite_E  = 1'b1;
        MemtoReg_E  = 1'b1;
        aluResult_E = 64'h48;
        rd_E        = 5'd20;
        @(negedge clk);
        valid_E = 1'b0;
        checkOutput("rst_access_req1", 64'(dmem_req), 64'd1);
        @(negedge clk);
        checkOutput("rst_access_req2", 64'(dmem_req), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_dmem_req", 64'(dmem_req), 64'd0);
        checkOutput("rst_stall_E", 64'(stall_E), 64'd0);
        checkOutput("rst_dmem_addr", dmem_addr, 64'd0);
        checkOutput("rst_valid_M", 64'(valid_M), 64'd0);
        checkOutput("rst_aluResult_M", aluResult_M, 64'd0);
        checkOutput("rst_RegWrite_M", 64'(RegWrite_M), 64'd0);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("rst_no_valid_M", 64'(valid_M), 64'd0);
        end

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", 64'(expectQ.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 Parameters SHALL be: N, default 64, datapath width; TIMEOUT, default 16, maximum cycles to wait for dmem_ack.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-low reset (reset=0 resets on the next rising clk edge).
REQ-004 valid_E  in  1  execute-stage result present this cycle.
REQ-005 aluResult_E / writeData_E / PCBranch_E  in  N each  ALU result (memory address), store data, branch target.
REQ-006 zero_E, Branch_E, MemRead_E, MemWrite_E, RegWrite_E, MemtoReg_E  in  1 each  execute flag and control bits.
REQ-007 rd_E  in  5  destination register index.
REQ-008 stall_E  out  1  execute side must hold its outputs; capture is blocked.
REQ-009 dmem_req, dmem_we  out  1 each  memory request and write enable.
REQ-010 dmem_addr / dmem_wdata  out  N each  memory address and store data.
REQ-011 dmem_ack  in  1; dmem_rdata  in  N  completion; read data is valid in the ack cycle.
REQ-012 valid_M  out  1  one-cycle pulse; all _M outputs are valid.
REQ-013 readData_M / aluResult_M / PCBranch_M  out  N each; rd_M  out  5.
REQ-014 RegWrite_M, MemtoReg_M, PCSrc_M, err_M  out  1 each.

Function
REQ-015 FSM states SHALL be IDLE and ACCESS, with IDLE as the reset state.
REQ-016 Capture SHALL occur when valid_E=1 and stall_E=0, and SHALL load all _E inputs into the EX/MEM register.
REQ-017 stall_E SHALL equal (state==ACCESS).
REQ-018 A captured non-memory op (MemRead_E=MemWrite_E=0) SHALL pulse valid_M on the next cycle, with latency 1, and the FSM SHALL stay in IDLE.
REQ-019 A captured legal memory op SHALL move the FSM IDLE->ACCESS, and dmem_req SHALL be 1 from the next cycle until the ack cycle inclusive.
REQ-020 During ACCESS, dmem_addr, dmem_wdata and dmem_we (=MemWrite) SHALL be driven from the register and held stable.
REQ-021 On dmem_ack in ACCESS, the block SHALL latch dmem_rdata into readData_M, pulse valid_M on the next cycle and return to IDLE; dmem_req SHALL drop on the cycle after ack.
REQ-022 valid_M SHALL pulse exactly once per captured op; readData_M SHALL be 0 for non-load ops.
REQ-023 PCSrc_M SHALL equal Branch & zero of the captured op, and SHALL be meaningful only while valid_M=1.
REQ-024 The wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without ack.
REQ-025 If the counter reaches TIMEOUT-1 with no ack, the block SHALL abort: drop dmem_req, pulse valid_M with err_M=1, and go to IDLE.
REQ-026 If ack coincides with the timeout cycle, the ack SHALL win and err_M SHALL be 0.
REQ-027 MemRead=MemWrite=1, or a memory address with bits [2:0]≠0, SHALL be illegal: no request issued, valid_M next cycle with err_M=1.
REQ-028 Whenever err_M=1, RegWrite_M SHALL be forced to 0.
REQ-029 A dmem_ack received while in IDLE SHALL be ignored.
REQ-030 Back-to-back non-memory ops SHALL sustain a throughput of one per cycle.

Reset
REQ-031 While reset=0, at the clock edge: state=IDLE, counter=0, and all outputs SHALL be 0 (stall_E, dmem_*, every _M output, err_M).
REQ-032 Reset asserted during ACCESS SHALL drop dmem_req on that edge, and no valid_M SHALL be emitted for the aborted op.

Structure
REQ-033 The mem_state_t enum and the TIMEOUT default SHALL live in the shared package legv8_pkg.
REQ-034 The EX/MEM register SHALL use the existing flopr sub-module with an enable added; all other logic SHALL be inline.

Verification
REQ-035 Non-memory op: ADD with aluResult_E=0x10, RegWrite_E=1 -> valid_M=1 next cycle, aluResult_M=0x10, stall_E never asserted.
REQ-036 Load: addr 0x40, ack after 3 cycles with rdata 0xDEAD -> dmem_req high for 3 cycles, stall_E high, readData_M=0xDEAD, err_M=0.
REQ-037 Store with ack never asserted, TIMEOUT=16 -> dmem_req drops after 16 cycles, valid_M=1, err_M=1, RegWrite_M=0.
REQ-038 Misaligned load at addr 0x43 -> dmem_req stays 0, valid_M next cycle, err_M=1.
REQ-039 Branch_E=1, zero_E=1, PCBranch_E=0x100 -> PCSrc_M=1, PCBranch_M=0x100; repeat with zero_E=0 -> PCSrc_M=0.
REQ-040 Reset=0 applied on 2nd ACCESS cycle -> all outputs 0 on that edge; no valid_M afterwards.
